// File: rtl/alarm_sequencer.sv
// Alarm sequencer FSM: arm, fire on time match, stop, motion snooze, ring timeout.
// Optional macro SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE.
module alarm_sequencer #(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       secTick,
    input  logic       alarmEn,
    input  logic [7:0] alarmHr,
    input  logic [7:0] alarmMin,
    input  logic [7:0] currHour,
    input  logic [7:0] currMin,
    input  logic       stopBtn,
    input  logic       motionDetected,
    output logic       alarmOut,
    output logic       snoozeActive,
    output logic       missed,
    output logic [1:0] state,
    output logic [2:0] snoozeCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        RINGING = 2'b10,
        SNOOZE  = 2'b11
    } state_e;

    localparam logic [15:0] RING_LAST   = 16'(RING_TIMEOUT_S - 1);
    localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_MIN * 60 - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  snz_q, snz_d;
    logic        missed_q, missed_d;
    logic        match_prev_q;
    logic        out_q, snz_act_q;
    logic        match, match_rise, snooze_ok;

    assign match      = (currHour == alarmHr) && (currMin == alarmMin);
    assign match_rise = match && !match_prev_q;

`ifdef SNOOZE_LIMIT_EN
    assign snooze_ok = (snz_q < 3'(MAX_SNOOZE));
`else
    assign snooze_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        snz_d    = snz_q;
        missed_d = missed_q;
        if (!alarmEn) begin
            state_d  = IDLE;
            snz_d    = '0;
            missed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED: begin
                    if (match_rise) begin
                        state_d  = RINGING;
                        snz_d    = '0;
                        missed_d = 1'b0;
                    end
                end
                RINGING: begin
                    if (stopBtn) begin
                        state_d = ARMED;
                    end else if (secTick && cnt_q == RING_LAST) begin
                        state_d  = ARMED;
                        missed_d = 1'b1;
                    end else if (motionDetected && snooze_ok) begin
                        state_d = SNOOZE;
                        if (snz_q != 3'd7) snz_d = snz_q + 3'd1;
                    end
                end
                SNOOZE: begin
                    if (stopBtn) begin
                        state_d = ARMED;
                    end else if (secTick && cnt_q == SNOOZE_LAST) begin
                        state_d = RINGING;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter restarts on every state change, so a tick on the entry cycle is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || state_q == IDLE || state_q == ARMED) begin
            cnt_d = '0;
        end else if (secTick && cnt_q != '1) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            snz_q        <= '0;
            missed_q     <= 1'b0;
            match_prev_q <= 1'b1;
            out_q        <= 1'b0;
            snz_act_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snz_q        <= snz_d;
            missed_q     <= missed_d;
            match_prev_q <= match;
            out_q        <= (state_d == RINGING);
            snz_act_q    <= (state_d == SNOOZE);
        end
    end

    assign alarmOut     = out_q;
    assign snoozeActive = snz_act_q;
    assign missed       = missed_q;
    assign state        = state_q;
    assign snoozeCount  = snz_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: stimulus pushes model expectations, monitor compares each cycle.
module tb_alarm_sequencer;

    localparam int unsigned T_RING  = 5;
    localparam int unsigned T_SNZ   = 1;
    localparam int unsigned T_MAX   = 3;
    localparam int          SNZ_TKS = T_SNZ * 60;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       secTick = 1'b0, alarmEn = 1'b0, stopBtn = 1'b0, motionDetected = 1'b0;
    logic [7:0] alarmHr = 8'd7, alarmMin = 8'd30, currHour = 8'd7, currMin = 8'd29;
    logic       alarmOut, snoozeActive, missed;
    logic [1:0] state;
    logic [2:0] snoozeCount;

    alarm_sequencer #(
        .RING_TIMEOUT_S(T_RING),
        .SNOOZE_MIN    (T_SNZ),
        .MAX_SNOOZE    (T_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .secTick       (secTick),
        .alarmEn       (alarmEn),
        .alarmHr       (alarmHr),
        .alarmMin      (alarmMin),
        .currHour      (currHour),
        .currMin       (currMin),
        .stopBtn       (stopBtn),
        .motionDetected(motionDetected),
        .alarmOut      (alarmOut),
        .snoozeActive  (snoozeActive),
        .missed        (missed),
        .state         (state),
        .snoozeCount   (snoozeCount)
    );

    always #5 clk = ~clk;

    int exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 armed, 2 ringing, 3 snooze
    int m_mode = 0, m_secs = 0, m_snz = 0;
    bit m_missed = 0, m_prev = 1;
    int cur_mn = 29;

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h (out,snz,miss,st[1:0],cnt[2:0]) expected %0h", name, $time, act, req);
        end
    endtask

    function automatic int outs_now();
        return int'({alarmOut, snoozeActive, missed, state, snoozeCount});
    endfunction

    function automatic int model_out();
        int v;
        v = ((m_mode == 2) ? 128 : 0) + ((m_mode == 3) ? 64 : 0) + (m_missed ? 32 : 0)
            + (m_mode * 8) + m_snz;
        return v;
    endfunction

    function automatic bit may_snooze();
`ifdef SNOOZE_LIMIT_EN
        return m_snz < int'(T_MAX);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step(bit en, bit tick, bit stop, bit mot, int mn);
        bit match, rise;
        int nxt;
        match = (mn == 30);
        rise  = match && !m_prev;
        nxt   = m_mode;
        if (!en) begin
            nxt = 0; m_snz = 0; m_missed = 0;
        end else if (m_mode == 0) begin
            nxt = 1;
        end else if (m_mode == 1) begin
            if (rise) begin nxt = 2; m_snz = 0; m_missed = 0; end
        end else if (m_mode == 2) begin
            if (stop) nxt = 1;
            else if (tick && m_secs + 1 == int'(T_RING)) begin nxt = 1; m_missed = 1; end
            else if (mot && may_snooze()) begin nxt = 3; m_snz = (m_snz < 7) ? m_snz + 1 : 7; end
        end else begin
            if (stop) nxt = 1;
            else if (tick && m_secs + 1 == SNZ_TKS) nxt = 2;
        end
        if (nxt != m_mode || nxt < 2) m_secs = 0;
        else if (tick && m_secs < 65535) m_secs++;
        m_mode = nxt;
        m_prev = match;
    endtask

    task automatic step(bit en, bit tick, bit stop, bit mot);
        @(negedge clk);
        alarmEn = en; secTick = tick; stopBtn = stop; motionDetected = mot;
        currMin = 8'(cur_mn);
        model_step(en, tick, stop, mot, cur_mn);
        exp_q.push_back(model_out());
        @(posedge clk);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 0);
            step(1, 1, 0, 0);
        end
    endtask

    task automatic fire();
        cur_mn = 31; step(1, 0, 0, 0);
        cur_mn = 30; step(1, 0, 0, 0);
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle_outputs", outs_now(), e);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        #2 reset = 1'b0;
        #3 check("reset_state", outs_now(), 0);
        @(negedge clk) reset = 1'b1;

        // arm at 07:29, then the minute rolls to 07:30
        cur_mn = 29;
        repeat (3) step(1, 0, 0, 0);
        cur_mn = 30; step(1, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        // stop; same minute must not refire
        step(1, 0, 1, 0);
        repeat (4) step(1, 1, 0, 0);

        // snooze then re-ring after the snooze tick count
        fire();
        step(1, 0, 0, 1);
        ticks(SNZ_TKS);
        repeat (2) step(1, 0, 0, 0);
        // timeout while ringing
        ticks(T_RING);
        repeat (3) step(1, 0, 0, 0);

        // repeated snoozes, the fourth exercises the limit
        fire();
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 1);
            ticks(SNZ_TKS);
            step(1, 0, 0, 0);
        end
        step(1, 0, 1, 0);

        // stop and motion together
        fire();
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);

        // disarm during snooze, re-arm while matching
        fire();
        step(1, 0, 0, 1);
        ticks(3);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);

        // async reset mid-ring
        fire();
        step(1, 1, 0, 0);
        #3 reset = 1'b0;
        #1 check("async_reset_mid_ring", outs_now(), 0);
        m_mode = 0; m_secs = 0; m_snz = 0; m_missed = 0; m_prev = 1;
        @(negedge clk) reset = 1'b1;
        repeat (4) step(1, 0, 0, 0);

        // randomized traffic around the alarm minute
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) cur_mn = 29 + int'($urandom_range(0, 2));
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 6);
        end

        repeat (2) step(1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
